// File: rtl/bram_fifo_ctrl_pkg.sv
// bram_fifo_ctrl_pkg: shared 32-bit word width (DW) and the LOG2 width helper macro
`ifndef LOG2
`define LOG2(x) $clog2(x)
`endif
package bram_fifo_ctrl_pkg;
  localparam int DW = 32;
endpackage

// File: rtl/bram_fifo_ctrl_if.sv
// bram_fifo_ctrl_if: FIFO bus (clear, wr_valid/wr_ready/wr_data, rd_valid/rd_ready/rd_data, level); master=user, slave=fifo
interface bram_fifo_ctrl_if #(parameter int DEPTH = 256);
  import bram_fifo_ctrl_pkg::*;
  localparam int AW = `LOG2(DEPTH);
  logic clear, wr_valid, wr_ready, rd_valid, rd_ready;
  logic [DW-1:0] wr_data, rd_data;
  logic [AW:0] level;
  modport master (output clear, wr_valid, wr_data, rd_ready, input wr_ready, rd_valid, rd_data, level);
  modport slave (input clear, wr_valid, wr_data, rd_ready, output wr_ready, rd_valid, rd_data, level);
endinterface

// File: rtl/bram_fifo_ctrl_ram.sv
// block_ram_32: dual-port SIZE x 32 RAM (clk, clk_en, wr_en/wr_addr/wr_data, rd_addr -> registered rd_data, old data on collision)
module block_ram_32 import bram_fifo_ctrl_pkg::*; #(
  parameter int SIZE = 256,
  localparam int AW = `LOG2(SIZE)
) (
  input  logic          clk,
  input  logic          clk_en,
  input  logic          wr_en,
  input  logic [AW-1:0] wr_addr,
  input  logic [DW-1:0] wr_data,
  input  logic [AW-1:0] rd_addr,
  output logic [DW-1:0] rd_data
);
  logic [DW-1:0] mem [SIZE];
  always_ff @(posedge clk)
    if (clk_en && wr_en) mem[wr_addr] <= wr_data;
  always_ff @(posedge clk)
    if (clk_en) rd_data <= mem[rd_addr];
endmodule

// File: rtl/bram_fifo_ctrl.sv
// bram_fifo_ctrl: FWFT FIFO sequencing block_ram_32 (clk, async rst_n, bus: clear, wr/rd handshakes, rd_data, level)
module bram_fifo_ctrl import bram_fifo_ctrl_pkg::*; #(
  parameter int DEPTH = 256
) (
  input logic             clk,
  input logic             rst_n,
  bram_fifo_ctrl_if.slave bus
);
  localparam int AW = `LOG2(DEPTH);
  logic [AW-1:0] wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d, rd_addr;
  logic [AW:0] level_q, level_d;
  logic rd_valid_q, rd_valid_d, push, pop;
  always_comb begin
    push = bus.wr_valid && bus.wr_ready && !bus.clear;
    pop = rd_valid_q && bus.rd_ready;
    rd_addr = rd_ptr_q + AW'(pop);
    wr_ptr_d = bus.clear ? '0 : wr_ptr_q + AW'(push);
    rd_ptr_d = bus.clear ? '0 : rd_addr;
    level_d = bus.clear ? '0 : level_q + (AW+1)'(push) - (AW+1)'(pop);
    // a head word written this cycle cannot be read back until the next read issue
    rd_valid_d = !bus.clear && level_d != '0 && !(push && wr_ptr_q == rd_addr);
  end
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      level_q <= '0;
      rd_valid_q <= 1'b0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      level_q <= level_d;
      rd_valid_q <= rd_valid_d;
    end
  assign bus.wr_ready = level_q != (AW+1)'(DEPTH);
  assign bus.rd_valid = rd_valid_q;
  assign bus.level = level_q;
  block_ram_32 #(.SIZE(DEPTH)) u_ram (
    .clk(clk),
    .clk_en(1'b1),
    .wr_en(push),
    .wr_addr(wr_ptr_q),
    .wr_data(bus.wr_data),
    .rd_addr(rd_addr),
    .rd_data(bus.rd_data)
  );
endmodule

// File: doc/bram_fifo_ctrl.md
Name: bram_fifo_ctrl

Overview:
- Synchronous FIFO controller that sequences one dual-port block_ram_32 instance as a first-word-fall-through queue.
- Owns write/read pointers, occupancy and the RAM's one-cycle read latency.
- Presents valid/ready handshakes to a producer and a consumer.
- Used wherever the design buffers 32-bit words between pipeline stages running at different rates.

Parameters:
- DEPTH, 256, number of 32-bit words; power of 2, at least 4; passed to block_ram_32 SIZE.
- AW, `LOG2(DEPTH), pointer width; derived, not overridden.

Ports:
- clk  in  1  system clock; all state updates on rising edge.
- rst_n  in  1  asynchronous active-low reset.
- clear  in  1  synchronous flush; discards all contents.
- wr_valid  in  1  producer offers wr_data.
- wr_ready  out  1  FIFO can accept; high iff not full.
- wr_data  in  32  word to enqueue.
- rd_valid  out  1  rd_data holds the head word.
- rd_ready  in  1  consumer takes the head word.
- rd_data  out  32  head word; driven directly by block_ram_32 rd_data.
- level  out  AW+1  occupancy in words, 0..DEPTH.

Behaviour:
- Reset, async on rst_n low:
  - wr_ptr=0, rd_ptr=0, level=0, rd_valid=0, wr_ready=1.
  - rd_data is undefined until the first rd_valid.
- Push when wr_valid&&wr_ready; pop when rd_valid&&rd_ready. No other events change state.
- block_ram_32 connections:
  - clk_en tied 1.
  - wr_addr=wr_ptr[AW-1:0], fed every cycle.
  - rd_addr combinational: rd_ptr+1 on a pop cycle, else rd_ptr. A held head is re-read every cycle, so rd_data is stable while rd_valid&&!rd_ready.
- Pointers: AW bits, wrap modulo DEPTH; increment on push/pop respectively.
- level: +1 on push only, -1 on pop only, unchanged on both or neither. wr_ready=(level!=DEPTH), from registered level.
- Read-during-write returns old data. Visibility rule:
  - A word becomes readable only when its RAM read is issued at least one cycle after its write.
  - rd_valid at cycle t+1 = (head word written at cycle ≤ t-1) && level>0 after the t edge.
- Write-to-rd_valid latency into an empty FIFO: word pushed at cycle t gives rd_valid high at t+2 with correct rd_data.
- Throughput: one push and one pop per cycle sustained once level≥2.
- Boundaries:
  - Full: wr_ready=0. A simultaneous pop does not open wr_ready in the same cycle; it reopens the next cycle.
  - Empty: rd_valid=0; rd_ready ignored.
  - level==1, pop and push in the same cycle: rd_valid low next cycle, then high the following cycle with the new word (visibility rule).
  - Wrap-around: pointers pass DEPTH-1→0 without a bubble.
  - clear: next cycle pointers=0, level=0, rd_valid=0, wr_ready=1. A push coinciding with clear is dropped.
  - rst_n asserted mid-transfer: all state returns to reset values immediately. RAM contents are not cleared and must not be observed.
- rd_data must never change while rd_valid&&!rd_ready. Assert this in the bench.

Decomposition:
- Shared definitions file: `LOG2 macro and a 32-bit data word width constant.
- No new package types.
- One natural sub-module: block_ram_32, instantiated unmodified (SIZE=DEPTH).
- All control, including the visibility tracking (a one-bit "head written last cycle" flag or equivalent), lives in bram_fifo_ctrl.

Test Plan:
- Reset, then single push of 0xDEADBEEF at cycle 5 with rd_ready=1 -> rd_valid high cycle 7, rd_data=0xDEADBEEF, popped; level 0→1→0; rd_valid low cycle 8.
- DEPTH=4: push 0x1..0x4 back-to-back with rd_ready=0 -> wr_ready low after 4th push, level=4. Fifth wr_valid is not accepted. Pop one -> wr_ready high next cycle.
- Continuous push/pop with 0..599 (DEPTH=4, >100 wraps), rd_ready=1 -> output sequence 0..599 in order, no duplicates, steady-state one word/cycle.
- Consumer stall: rd_valid with rd_ready=0 for 10 cycles while producer pushes 0xA5A5A5A5 -> rd_data unchanged throughout, level increments per push.
- level==1, simultaneous push 0x22 and pop of 0x11 -> rd_valid low one cycle, then rd_data=0x22 valid.
- clear at level=3, then rst_n pulsed low mid-stream -> both give level=0, rd_valid=0, wr_ready=1. Subsequent push/pop of 0x77 returns 0x77 only.
